fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core. It sits directly upstream of the instruction memory (64 words, 6-bit word address, combinational read).
- Holds the PC, drives the imem word address, and registers the returned instruction into an IF/ID pipeline register for decode.
- Supports stall, branch/jump redirect with flush, and a sticky fetch-fault FSM that halts fetch on a misaligned or out-of-range PC.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_AW, 6, imem word-address width. Fetchable range is byte addresses 0 .. 4*2^IMEM_AW-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use or downstream stall).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address.
- imem_a  out  IMEM_AW  word address to imem; equals pc[IMEM_AW+1:2].
- imem_rd  in  32  instruction word from imem (combinational, same cycle).
- pc  out  32  current fetch PC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  fetched instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pcplus4  out  32  if_id_pc + 4, mod 2^32.
- fetch_fault  out  1  sticky fault; fetch halted.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. It dominates all other inputs.
- Reset values: pc=RESET_PC, if_id_valid=0, if_id_instr=32'h0 (NOP), if_id_pc=0, if_id_pcplus4=0, fetch_fault=0, state=RUN. Reset asserted mid-operation discards any pending redirect or stall.
- imem_a is pc[IMEM_AW+1:2], purely combinational from the pc register. Fetch latency is one cycle: the instruction at pc appears on if_id_instr the cycle after pc is presented.
- Out-of-range condition (oor): pc[31:IMEM_AW+2] != 0. Evaluated combinationally on the current pc.
- FSM states: RUN, FAULT.
- RUN, per-cycle priority (highest first):
  1. redirect_valid=1:
     - If redirect_pc[1:0] != 0: go to FAULT and set fetch_fault=1. pc is unchanged. IF/ID is flushed (valid=0, instr=0).
     - Otherwise: pc <= redirect_pc. IF/ID is flushed (valid=0, instr=0, pc fields hold).
     - Redirect overrides stall.
  2. stall=1: pc and all IF/ID registers hold their values.
  3. oor=1: go to FAULT and set fetch_fault=1. IF/ID is flushed (valid=0). pc holds.
  4. Otherwise (normal fetch):
     - if_id_instr <= imem_rd
     - if_id_pc <= pc
     - if_id_pcplus4 <= pc+4
     - if_id_valid <= 1
     - pc <= pc+4
- FAULT:
  - pc holds and if_id_valid=0.
  - stall and redirect are ignored.
  - The only exit is reset.
- Arithmetic: pc+4 is a 32-bit add with wrap; 32'hFFFF_FFFC+4 = 0. The wrapped value then fails the oor check on the next cycle unless it is in range (0 is in range).
- imem_rd is sampled only on a normal-fetch cycle.
- pc is always word-aligned. A misaligned value can never be loaded into pc.

Decomposition:
- Shared package mips_pkg:
  - NOP constant 32'h0000_0000.
  - RESET_PC default.
  - fetch_state_t enum {RUN, FAULT}.
  - Instruction/address width constants (32).
- One sub-module is natural: if_id_reg, the IF/ID pipeline register with load/hold/flush controls and reset. It is reusable for the ID/EX register pattern.
- PC logic and FSM stay in fetch_stage.

Test Plan:
- Reset, then free-run with imem RAM[0]=32'h20010007 and RAM[1]=32'h20020008. Required response:
  - cycle 1: if_id_instr=32'h20010007, if_id_pc=0, if_id_pcplus4=4, valid=1.
  - cycle 2: instr=32'h20020008, if_id_pc=4.
  - imem_a sequence is 0,1,2.
- Stall at pc=8 for 3 cycles. Required response: pc stays 8, IF/ID holds the word-1 contents, imem_a=2. On release, the next capture has if_id_pc=8.
- redirect_valid with redirect_pc=32'h34 and stall=1 simultaneously. Required response:
  - next cycle: pc=32'h34, valid=0, instr=0.
  - following cycle: instr=RAM[13]=32'h10830001, if_id_pc=32'h34.
- redirect_pc=32'h0000_0036 (misaligned). Required response: fetch_fault=1, valid=0, pc unchanged. Later redirect to 0 is ignored. reset clears the fault and restores pc=0.
- redirect_pc=32'h100 (IMEM_AW=6). Required response:
  - next cycle: pc=32'h100, oor=1.
  - following cycle: fetch_fault=1, valid=0, pc holds 32'h100.
- Assert reset mid-run at pc=32'h14 while redirect_valid=1. Required response: pc=0, valid=0, redirect discarded.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core pipeline stages.
//   XLEN             - instruction and address width
//   NOP              - encoding used to fill a flushed pipeline register
//   RESET_PC_DEFAULT - default byte address the PC starts from after reset
//   fetch_state_t    - fetch FSM states
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage and imem.
//   imem_a  - word address driven by the fetch stage
//   imem_rd - instruction word returned combinationally by imem
// Modports: master (fetch stage side), slave (memory side).
interface fetch_stage_if
    import mips_pkg::*;
#(
    parameter int AW = 6
) ();

    logic [AW-1:0]   imem_a;
    logic [XLEN-1:0] imem_rd;

    modport master (output imem_a, input imem_rd);
    modport slave  (input imem_a, output imem_rd);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: generic pipeline register between two stages.
//   clk, reset       - clock and synchronous active-high reset
//   load             - capture the *_in values this cycle
//   flush            - invalidate the entry (valid=0, instr=NOP), pc fields hold
//   instr_in/pc_in/pcplus4_in - values captured on load
//   valid/instr/pc/pcplus4    - registered outputs
// Priority: reset > flush > load > hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4
);

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] instr_q,   instr_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;

    // A flush only kills the instruction; the pc fields are left alone so a
    // bubble still carries the address of the last real fetch.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = instr_in;
            pc_d      = pc_in;
            pcplus4_d = pcplus4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP;
            pc_q      <= '0;
            pcplus4_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign valid   = valid_q;
    assign instr   = instr_q;
    assign pc      = pc_q;
    assign pcplus4 = pcplus4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MIPS core.
//   clk, reset      - clock and synchronous active-high reset
//   stall           - hold PC and IF/ID
//   redirect_valid  - branch/jump taken; redirect_pc is the target byte address
//   imem            - imem bus (master): word address out, instruction in
//   pc              - current fetch PC
//   if_id_*         - IF/ID pipeline register contents for decode
//   fetch_fault     - sticky fault; fetch halted until reset
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    fetch_stage_if.master         imem,
    output logic [XLEN-1:0]       pc,
    output logic                  if_id_valid,
    output logic [XLEN-1:0]       if_id_instr,
    output logic [XLEN-1:0]       if_id_pc,
    output logic [XLEN-1:0]       if_id_pcplus4,
    output logic                  fetch_fault
);

    // The low two bits are cleared so even a misaligned parameter can never
    // put a misaligned value into the PC.
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            oor;
    logic            ifid_load;
    logic            ifid_flush;

    assign pc_plus4 = pc_q + 32'd4;

    // Any set bit above the imem word range means the PC is outside imem.
    assign oor = (pc_q[XLEN-1:IMEM_AW+2] != '0);

    // Next-state and control: redirect beats stall, stall beats the range
    // check, and FAULT is only left through reset.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (oor) begin
                    state_d    = FAULT;
                    ifid_flush = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end
            end
            FAULT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d    = FAULT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC_ALIGNED;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .instr_in   (imem.imem_rd),
        .pc_in      (pc_q),
        .pcplus4_in (pc_plus4),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .pcplus4    (if_id_pcplus4)
    );

    assign imem.imem_a = pc_q[IMEM_AW+1:2];
    assign pc          = pc_q;
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a
// 64-word combinational instruction memory model.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pcplus4;
    logic        fetch_fault;

    logic [31:0] ram [64];

    int n_compared;
    int n_mismatched;

    fetch_stage_if #(.AW(6)) imem_bus ();

    assign imem_bus.imem_rd = ram[imem_bus.imem_a];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus.master),
        .pc             (pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pcplus4  (if_id_pcplus4),
        .fetch_fault    (fetch_fault)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are settled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic stl,
                                 input logic rv, input logic [31:0] rpc);
        reset          = rst;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + 32'(i);
        ram[0]  = 32'h2001_0007;
        ram[1]  = 32'h2002_0008;
        ram[2]  = 32'h2003_0009;
        ram[13] = 32'h1083_0001;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_pc",      pc,                     32'h0);
        checkOutput("rst_valid",   32'(if_id_valid),       32'h0);
        checkOutput("rst_instr",   if_id_instr,            32'h0);
        checkOutput("rst_ifpc",    if_id_pc,               32'h0);
        checkOutput("rst_pcp4",    if_id_pcplus4,          32'h0);
        checkOutput("rst_fault",   32'(fetch_fault),       32'h0);
        checkOutput("rst_imem_a",  32'(imem_bus.imem_a),   32'h0);

        // Free run
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("c1_instr",    if_id_instr,            32'h2001_0007);
        checkOutput("c1_ifpc",     if_id_pc,               32'h0);
        checkOutput("c1_pcp4",     if_id_pcplus4,          32'h4);
        checkOutput("c1_valid",    32'(if_id_valid),       32'h1);
        checkOutput("c1_imem_a",   32'(imem_bus.imem_a),   32'h1);
        tick();
        checkOutput("c2_instr",    if_id_instr,            32'h2002_0008);
        checkOutput("c2_ifpc",     if_id_pc,               32'h4);
        checkOutput("c2_imem_a",   32'(imem_bus.imem_a),   32'h2);
        checkOutput("c2_pc",       pc,                     32'h8);

        // Stall for three cycles at pc=8
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stl_pc",     pc,                   32'h8);
            checkOutput("stl_imem_a", 32'(imem_bus.imem_a), 32'h2);
            checkOutput("stl_instr",  if_id_instr,          32'h2002_0008);
            checkOutput("stl_ifpc",   if_id_pc,             32'h4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("rel_ifpc",    if_id_pc,               32'h8);
        checkOutput("rel_instr",   if_id_instr,            32'h2003_0009);
        checkOutput("rel_pc",      pc,                     32'hC);

        // Redirect to 0x34 together with stall: redirect wins
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h34);
        tick();
        checkOutput("rd_pc",       pc,                     32'h34);
        checkOutput("rd_valid",    32'(if_id_valid),       32'h0);
        checkOutput("rd_instr",    if_id_instr,            32'h0);
        checkOutput("rd_ifpc",     if_id_pc,               32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("rd2_instr",   if_id_instr,            32'h1083_0001);
        checkOutput("rd2_ifpc",    if_id_pc,               32'h34);
        checkOutput("rd2_pcp4",    if_id_pcplus4,          32'h38);
        checkOutput("rd2_valid",   32'(if_id_valid),       32'h1);

        // Misaligned redirect faults; later redirect ignored; reset clears
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h36);
        tick();
        checkOutput("mis_fault",   32'(fetch_fault),       32'h1);
        checkOutput("mis_valid",   32'(if_id_valid),       32'h0);
        checkOutput("mis_pc",      pc,                     32'h38);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("flt_pc",      pc,                     32'h38);
        checkOutput("flt_fault",   32'(fetch_fault),       32'h1);
        checkOutput("flt_valid",   32'(if_id_valid),       32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("clr_pc",      pc,                     32'h0);
        checkOutput("clr_fault",   32'(fetch_fault),       32'h0);

        // Redirect out of range: fault one cycle after reaching 0x100
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        checkOutput("oor_pc",      pc,                     32'h100);
        checkOutput("oor_fault0",  32'(fetch_fault),       32'h0);
        checkOutput("oor_valid0",  32'(if_id_valid),       32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("oor_fault1",  32'(fetch_fault),       32'h1);
        checkOutput("oor_valid1",  32'(if_id_valid),       32'h0);
        checkOutput("oor_pc1",     pc,                     32'h100);
        tick();
        checkOutput("oor_pc2",     pc,                     32'h100);

        // Reset mid-run at pc=0x14 with a redirect pending
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("run_pc",      pc,                     32'h14);
        checkOutput("run_ifpc",    if_id_pc,               32'h10);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        checkOutput("mrst_pc",     pc,                     32'h0);
        checkOutput("mrst_valid",  32'(if_id_valid),       32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("post_pc",     pc,                     32'h4);
        checkOutput("post_instr",  if_id_instr,            32'h2001_0007);
        checkOutput("post_ifpc",   if_id_pc,               32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
